dram_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port data RAM (16-bit address, 8-bit data, one-cycle synchronous read) among several requesters. Typical requesters are the UART loader, the CPU and the UART dump engine. It replaces ad-hoc `cpu_enable` muxing with a registered request/grant handshake. Each requester can then access the RAM concurrently without a global phase switch. The block sits between the requesters and the `data_ram` instance, all in the `clk_out` domain.

---
 rtl/dram_arbiter.sv | 116 +++++++++++
 tb/tb_dram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous-read data RAM among NUM_REQ requesters.
// Registered request/grant handshake with a 2-stage read-return pipeline.
module dram_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_arb_en,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_ram_we,
    output logic [ADDR_W-1:0]         o_ram_addr,
    output logic [DATA_W-1:0]         o_ram_din,
    input  logic [DATA_W-1:0]         i_ram_dout,
    output logic                      o_idle
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_din;
    logic               r_rd_vld1;
    logic               r_rd_vld2;
    logic [PTR_W-1:0]   r_rd_idx1;
    logic [PTR_W-1:0]   r_rd_idx2;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_ptr_nxt;

    // A requester already holding gnt this cycle is excluded to avoid a double grant.
    assign w_elig = i_req & ~r_gnt & {NUM_REQ{i_arb_en}};

    // Cyclic search for the first eligible requester starting at r_ptr.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_idx     = '0;
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
        if (w_found) begin
            w_ptr_nxt = PTR_W'((int'(w_win) + 1) % NUM_REQ);
        end else begin
            w_ptr_nxt = r_ptr;
        end
    end

    // Grant register, RAM port drive and read-return tracking.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_rd_vld1  <= 1'b0;
            r_rd_vld2  <= 1'b0;
            r_rd_idx1  <= '0;
            r_rd_idx2  <= '0;
        end else begin
            r_gnt     <= '0;
            r_ram_we  <= 1'b0;
            r_rd_vld1 <= 1'b0;
            if (w_found) begin
                r_gnt[w_win] <= 1'b1;
                r_ram_we     <= i_req_we[w_win];
                r_ram_addr   <= i_req_addr[w_win*ADDR_W +: ADDR_W];
                r_ram_din    <= i_req_wdata[w_win*DATA_W +: DATA_W];
                r_rd_vld1    <= ~i_req_we[w_win];
                r_rd_idx1    <= w_win;
            end
            r_ptr     <= w_ptr_nxt;
            // Stage 2 lines up with ram_dout being valid for the granted read.
            r_rd_vld2 <= r_rd_vld1;
            r_rd_idx2 <= r_rd_idx1;
            r_rvalid  <= '0;
            if (r_rd_vld2) begin
                r_rvalid[r_rd_idx2] <= 1'b1;
                r_rdata             <= i_ram_dout;
            end
        end
    end

    assign o_gnt      = r_gnt;
    assign o_rvalid   = r_rvalid;
    assign o_rdata    = r_rdata;
    assign o_ram_we   = r_ram_we;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_din  = r_ram_din;
    assign o_idle     = ~|r_gnt & ~r_rd_vld2 & ~|r_rvalid;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: a RAM model plus grant/read-return scoreboards checked on the falling edge.
module tb_dram_arbiter;
    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arb_en = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_din;
    logic [DW-1:0]     ram_dout = '0;
    logic              idle;

    dram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_reset(reset), .i_arb_en(arb_en),
        .i_req(req), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
        .i_ram_dout(ram_dout), .o_idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {int cyc; int idx; logic we; logic [15:0] addr; logic [7:0] data;} gnt_t;
    typedef struct {int cyc; int idx; logic [7:0] data;} rd_t;
    gnt_t gq[$];
    rd_t  rq[$];

    // Unwritten locations read back a known address-derived pattern.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    logic [7:0] ram     [0:65535];
    bit         ram_wr  [0:65535];
    logic [7:0] ref_mem [0:65535];
    bit         ref_wr  [0:65535];

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr]    <= ram_din;
            ram_wr[ram_addr] <= 1'b1;
        end
        ram_dout <= ram_wr[ram_addr] ? ram[ram_addr] : pat(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic we, input logic [15:0] a, input logic [7:0] d);
        req[idx]              = 1'b1;
        req_we[idx]           = we;
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = d;
    endtask

    task automatic exp_gnt(input int c, input int idx, input logic we, input logic [15:0] a,
                           input logic [7:0] d, input bit rd_ret);
        gnt_t g;
        rd_t  r;
        g.cyc = c; g.idx = idx; g.we = we; g.addr = a; g.data = d;
        gq.push_back(g);
        if (we) begin
            ref_mem[a] = d;
            ref_wr[a]  = 1'b1;
        end else if (rd_ret) begin
            r.cyc = c + 2; r.idx = idx;
            r.data = ref_wr[a] ? ref_mem[a] : pat(a);
            rq.push_back(r);
        end
    endtask

    task automatic single(input int idx, input logic we, input logic [15:0] a, input logic [7:0] d);
        set_req(idx, we, a, d);
        exp_gnt(cyc + 1, idx, we, a, d, 1'b1);
        step();
        req[idx] = 1'b0;
        step();
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_gnt"},    32'(gnt), 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_rdata"},  32'(rdata), 32'd0);
        chk({tag, "_we"},     32'(ram_we), 32'd0);
        chk({tag, "_addr"},   32'(ram_addr), 32'd0);
        chk({tag, "_din"},    32'(ram_din), 32'd0);
        chk({tag, "_idle"},   32'(idle), 32'd1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_rst_outputs("reset");
        step();
    endtask

    task automatic drain();
        repeat (6) step();
    endtask

    // Scoreboard: every grant and every read return must match the next expected entry.
    always @(negedge clk) begin
        gnt_t g;
        rd_t  r;
        if (gnt != '0) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                g = gq.pop_front();
                chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
                chk("gnt_onehot", 32'(gnt), 32'd1 << g.idx);
                chk("ram_we", 32'(ram_we), 32'(g.we));
                chk("ram_addr", 32'(ram_addr), 32'(g.addr));
                if (g.we) chk("ram_din", 32'(ram_din), 32'(g.data));
            end
        end else begin
            chk("we_without_gnt", 32'(ram_we), 32'd0);
        end
        if (rvalid != '0) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 32'(rvalid), 32'd0);
            end else begin
                r = rq.pop_front();
                chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
                chk("rvalid_onehot", 32'(rvalid), 32'd1 << r.idx);
                chk("rdata", 32'(rdata), 32'(r.data));
            end
        end
    end

    initial begin
        int n;
        int idx;
        int j;

        apply_reset();

        // Requester 0: write 0xA5 to 0x1234, then read it back.
        n = cyc;
        set_req(0, 1'b1, 16'h1234, 8'hA5);
        exp_gnt(n + 1, 0, 1'b1, 16'h1234, 8'hA5, 1'b1);
        step();
        @(negedge clk);
        chk("idle_busy", 32'(idle), 32'd0);
        req[0] = 1'b0;
        step();
        single(0, 1'b0, 16'h1234, 8'h00);
        drain();
        chk("idle_after_t1", 32'(idle), 32'd1);

        // Address extremes.
        single(0, 1'b1, 16'h0000, 8'h01);
        single(0, 1'b1, 16'hFFFF, 8'hFE);
        single(0, 1'b0, 16'h0000, 8'h00);
        single(0, 1'b0, 16'hFFFF, 8'h00);
        drain();

        // Three continuous readers from a fresh pointer: order 0,1,2,0,1,2.
        apply_reset();
        n = cyc;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 16'(256 * (i + 1)), 8'h00);
        for (int k = 1; k <= 6; k++) begin
            exp_gnt(n + k, (k - 1) % 3, 1'b0, 16'(256 * ((k - 1) % 3 + 1) + (k - 1) / 3), 8'h00, 1'b1);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            idx = (k - 1) % 3;
            j   = (k - 1) / 3;
            if (k <= 3) set_req(idx, 1'b0, 16'(256 * (idx + 1) + j + 1), 8'h00);
            else req[idx] = 1'b0;
        end
        drain();

        // arb_en low for 5 cycles with req1 pending.
        arb_en = 1'b0;
        set_req(1, 1'b0, 16'h0300, 8'h00);
        repeat (5) begin
            @(negedge clk);
            chk("idle_disabled", 32'(idle), 32'd1);
            chk("gnt_disabled", 32'(gnt), 32'd0);
            step();
        end
        arb_en = 1'b1;
        exp_gnt(cyc + 1, 1, 1'b0, 16'h0300, 8'h00, 1'b1);
        step();
        req[1] = 1'b0;
        drain();

        // Requester 2 alone with req held high: a grant every other cycle.
        n = cyc;
        set_req(2, 1'b0, 16'h0777, 8'h00);
        for (int k = 0; k < 4; k++) exp_gnt(n + 1 + 2 * k, 2, 1'b0, 16'h0777, 8'h00, 1'b1);
        repeat (7) step();
        req[2] = 1'b0;
        drain();

        // Reset in the gnt cycle of a read: its rvalid is dropped.
        n = cyc;
        set_req(0, 1'b0, 16'h0042, 8'h00);
        exp_gnt(n + 1, 0, 1'b0, 16'h0042, 8'h00, 1'b0);
        step();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk_rst_outputs("reset_mid");
        set_req(0, 1'b0, 16'h0050, 8'h00);
        set_req(1, 1'b0, 16'h0051, 8'h00);
        exp_gnt(n + 3, 0, 1'b0, 16'h0050, 8'h00, 1'b1);
        exp_gnt(n + 4, 1, 1'b0, 16'h0051, 8'h00, 1'b1);
        step();
        req[0] = 1'b0;
        step();
        req[1] = 1'b0;
        drain();

        chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
        chk("rd_queue_empty", 32'(rq.size()), 32'd0);
        chk("idle_final", 32'(idle), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
